// File: rtl/mips_run_monitor.sv
// Run controller wrapped around the MIPS core: sequences core reset, counts RUN cycles and
// GRF write-backs, and ends the run on a PC halt loop or when the cycle budget runs out.
module mips_run_monitor #(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_REPEAT  = 3,
    parameter int MAX_CYCLES   = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [PC_WIDTH-1:0]  cpu_pc,
    input  logic                 grf_we,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [PC_WIDTH-1:0]  halt_pc,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int SAME_W = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [SAME_W-1:0]    SAME_LAST = SAME_W'(HALT_REPEAT - 1);
    localparam logic [CNT_WIDTH-1:0] CYC_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [SAME_W-1:0]     same_cnt_q, same_cnt_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
    logic                  core_reset_q, core_reset_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [PC_WIDTH-1:0]   halt_pc_q, halt_pc_d;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]  wb_cnt_q, wb_cnt_d;
    logic                  match;
    logic                  halt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign match = prev_valid_q && (cpu_pc == prev_pc_q);
    assign halt  = match && (same_cnt_q == SAME_LAST);

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        same_cnt_d   = same_cnt_q;
        prev_valid_d = prev_valid_q;
        prev_pc_d    = prev_pc_q;
        core_reset_d = core_reset_q;
        running_d    = 1'b0;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        halt_pc_d    = halt_pc_q;
        cycle_cnt_d  = cycle_cnt_q;
        wb_cnt_d     = wb_cnt_q;

        unique case (state_q)
            ST_RST_HOLD: begin
                core_reset_d = 1'b1;
                hold_cnt_d   = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                end
            end

            ST_RUN: begin
                core_reset_d = 1'b0;
                running_d    = 1'b1;
                cycle_cnt_d  = sat_inc(cycle_cnt_q);
                wb_cnt_d     = grf_we ? sat_inc(wb_cnt_q) : wb_cnt_q;
                prev_pc_d    = cpu_pc;
                prev_valid_d = 1'b1;
                same_cnt_d   = match ? same_cnt_q + 1'b1 : '0;
                // Halt is checked first so a halt on the budget's last cycle is not a timeout.
                if (halt) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    halt_pc_d = cpu_pc;
                    timeout_d = 1'b0;
                end else if (cycle_cnt_q == CYC_LAST) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    halt_pc_d = '0;
                    timeout_d = 1'b1;
                end
            end

            ST_DONE: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
                if (restart) begin
                    state_d      = ST_RST_HOLD;
                    core_reset_d = 1'b1;
                    done_d       = 1'b0;
                    hold_cnt_d   = '0;
                    same_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                    timeout_d    = 1'b0;
                    halt_pc_d    = '0;
                    cycle_cnt_d  = '0;
                    wb_cnt_d     = '0;
                end
            end

            default: begin
                state_d      = ST_RST_HOLD;
                core_reset_d = 1'b1;
                hold_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RST_HOLD;
            hold_cnt_q   <= '0;
            same_cnt_q   <= '0;
            prev_valid_q <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            halt_pc_q    <= '0;
            cycle_cnt_q  <= '0;
            wb_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            same_cnt_q   <= same_cnt_d;
            prev_valid_q <= prev_valid_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            halt_pc_q    <= halt_pc_d;
            cycle_cnt_q  <= cycle_cnt_d;
            wb_cnt_q     <= wb_cnt_d;
        end
    end

    // prev_pc is only meaningful while prev_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        prev_pc_q <= prev_pc_d;
    end

    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign halt_pc    = halt_pc_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign wb_cnt     = wb_cnt_q;

endmodule
